// File: rtl/mdu_seq.sv
// mdu_seq -- iterative RV32M multiply/divide sequencer.
//
// Executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over multiple cycles, so the
// single-cycle ALU needs no array multiplier or divider. Multiplies use
// shift-add on operand magnitudes; divides use restoring division on
// magnitudes. Sign correction is applied in a dedicated FIX state.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   flush              synchronous kill of the in-flight operation
//   in_valid/in_ready  request handshake (in_ready = state is IDLE)
//   op, a, b           funct3 and rs1/rs2 operands, latched on accept
//   out_valid/out_ready result handshake, result held while stalled
//   result             operation result
//   busy               state is not IDLE
//
// Optional feature macro: MDU_FAST_MUL_EN
//   When defined, multiplies are computed combinationally and registered on
//   the accept edge. When undefined, no combinational multiplier exists.
module mdu_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam logic [2:0] OP_MUL = 3'b000;
  localparam logic [2:0] OP_DIV = 3'b100;
  localparam logic [2:0] OP_REM = 3'b110;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        op_r;
  logic              neg_r;
  // Multiply: {partial product high, multiplier/low product}.
  // Divide:   {partial remainder, dividend/quotient}.
  logic [2*XLEN-1:0] acc;
  // Multiplicand (multiply) or divisor (divide) magnitude.
  logic [XLEN-1:0]   dvs;

  function automatic logic [XLEN-1:0] cneg(input logic [XLEN-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cneg_w(input logic [2*XLEN-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // Request decode: signedness, magnitudes and special cases
  logic            a_sgn, b_sgn, neg_a, neg_b;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            b_zero, div_ovf, special;
  logic [XLEN-1:0] special_res;
  logic            neg_in;

  always_comb begin
    // a is signed for MUL, MULH, MULHSU, DIV, REM; b for MUL, MULH, DIV, REM.
    a_sgn   = op[2] ? ~op[0] : (op != 3'b011);
    b_sgn   = op[2] ? ~op[0] : ~op[1];
    neg_a   = a_sgn & a[XLEN-1];
    neg_b   = b_sgn & b[XLEN-1];
    mag_a   = cneg(a, neg_a);
    mag_b   = cneg(b, neg_b);
    b_zero  = (b == '0);
    div_ovf = ((op == OP_DIV) || (op == OP_REM)) &&
              (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    special = op[2] & (b_zero | div_ovf);
    if (b_zero)
      special_res = op[1] ? a : '1;
    else
      special_res = op[1] ? '0 : a;
    // Remainder follows the dividend sign; product and quotient follow the XOR.
    neg_in  = (op[2] & op[1]) ? neg_a : (neg_a ^ neg_b);
  end

`ifdef MDU_FAST_MUL_EN
  logic signed [2*XLEN-1:0] fast_a, fast_b, fast_p;
  logic [XLEN-1:0]          fast_res;

  always_comb begin
    fast_a   = {{XLEN{a_sgn & a[XLEN-1]}}, a};
    fast_b   = {{XLEN{b_sgn & b[XLEN-1]}}, b};
    fast_p   = fast_a * fast_b;
    fast_res = (op == OP_MUL) ? fast_p[XLEN-1:0] : fast_p[2*XLEN-1:XLEN];
  end
`endif

  // One iteration of shift-add multiply and restoring divide
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_sh, div_diff;
  logic [2*XLEN-1:0] div_next;

  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, dvs} : {(XLEN+1){1'b0}});
    mul_next = {mul_sum, acc[XLEN-1:1]};
    div_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff = div_sh - {1'b0, dvs};
    // A borrow means the shifted remainder is below the divisor: restore.
    if (div_diff[XLEN])
      div_next = {div_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    else
      div_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
  end

  // Sign correction and result selection
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   fix_res;

  always_comb begin
    prod = cneg_w(acc, neg_r);
    if (op_r[2])
      fix_res = op_r[1] ? cneg(acc[2*XLEN-1:XLEN], neg_r) : cneg(acc[XLEN-1:0], neg_r);
    else
      fix_res = (op_r == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  // Sequencer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      op_r      <= '0;
      neg_r     <= 1'b0;
      acc       <= '0;
      dvs       <= '0;
      out_valid <= 1'b0;
      result    <= '0;
    end else if (flush) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_r  <= op;
            neg_r <= neg_in;
            acc   <= {{XLEN{1'b0}}, (op[2] ? mag_a : mag_b)};
            dvs   <= op[2] ? mag_b : mag_a;
            cnt   <= '0;
            if (special) begin
              result    <= special_res;
              out_valid <= 1'b1;
              state     <= DONE;
            end
`ifdef MDU_FAST_MUL_EN
            else if (!op[2]) begin
              result    <= fast_res;
              out_valid <= 1'b1;
              state     <= DONE;
            end
`endif
            else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          acc <= op_r[2] ? div_next : mul_next;
          if (cnt == CNT_W'(XLEN-1)) begin
            cnt   <= '0;
            state <= FIX;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        FIX: begin
          result    <= fix_res;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
